// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue (default widths, NOP encoding, reset PC).
package fetch_queue_pkg;

  localparam int unsigned FQ_XLEN      = 32;
  localparam int unsigned FQ_DEPTH     = 4;
  localparam logic [31:0] FQ_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] FQ_RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue; slave is the queue's view, master the surrounding pipeline.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = FQ_XLEN,
  parameter int unsigned DEPTH = FQ_DEPTH
);

  logic                   if_valid;
  logic [XLEN-1:0]        if_pc;
  logic [XLEN-1:0]        if_instr;
  logic                   if_ready;
  logic                   id_valid;
  logic [XLEN-1:0]        id_pc;
  logic [XLEN-1:0]        id_instr;
  logic                   id_ready;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output if_valid, if_pc, if_instr, id_ready, flush,
    input  if_ready, id_valid, id_pc, id_instr, count
  );

  modport slave (
    input  if_valid, if_pc, if_instr, id_ready, flush,
    output if_ready, id_valid, id_pc, id_instr, count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous read port.
module fetch_queue_mem #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Entry contents carry no reset; occupancy is tracked by the pointers in the parent.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue replacing the IF/ID register: pointer/count FIFO with synchronous flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue passes if_* straight to id_* in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN      = FQ_XLEN,
  parameter int unsigned     DEPTH     = FQ_DEPTH,
  parameter logic [XLEN-1:0] NOP_INSTR = FQ_NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave q
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              full_s;
  logic              empty_s;
  logic              bypass_s;
  logic              push_s;
  logic              pop_s;
  logic              wr_en_s;
  logic [2*XLEN-1:0] rd_data_s;
  logic              id_valid_s;
  logic [XLEN-1:0]   id_pc_s;
  logic [XLEN-1:0]   id_instr_s;

  // Handshake qualification from registered occupancy; flush kills both sides.
  always_comb begin
    full_s  = (count_q == CW'(DEPTH));
    empty_s = (count_q == {CW{1'b0}});
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s = empty_s & q.if_valid & ~q.flush;
`else
    bypass_s = 1'b0;
`endif
    push_s  = q.if_valid & ~full_s & ~q.flush;
    pop_s   = ~empty_s & q.id_ready & ~q.flush;
    // A bypassed pair that decode takes immediately is never written.
    wr_en_s = push_s & ~(bypass_s & q.id_ready);
  end

  // Next pointer and occupancy state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i ({q.if_pc, q.if_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_s)
  );

  // Decode-side view: bypass pair, else head entry, else a NOP bubble.
  always_comb begin
    id_valid_s = ~empty_s | bypass_s;
    if (bypass_s) begin
      id_pc_s    = q.if_pc;
      id_instr_s = q.if_instr;
    end else if (!empty_s) begin
      id_pc_s    = rd_data_s[2*XLEN-1:XLEN];
      id_instr_s = rd_data_s[XLEN-1:0];
    end else begin
      id_pc_s    = {XLEN{1'b0}};
      id_instr_s = NOP_INSTR;
    end
  end

  assign q.if_ready = ~full_s;
  assign q.id_valid = id_valid_s;
  assign q.id_pc    = id_pc_s;
  assign q.id_instr = id_instr_s;
  assign q.count    = count_q;

endmodule
